// File: rtl/anita_evbuf_pkg.sv
// Shared definitions for the ANITA event ring buffer.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package anita_evbuf_pkg;

    // Saturating dropped-event counter width.
    localparam int DROP_CNT_W = 8;

    // Bit positions and field widths within the 32-bit status word.
    localparam int STAT_RD_PTR_LSB = 0;
    localparam int STAT_WR_PTR_LSB = 4;
    localparam int STAT_PTR_W      = 4;
    localparam int STAT_MASK_LSB   = 8;
    localparam int STAT_MASK_W     = 8;
    localparam int STAT_VALID_BIT  = 16;
    localparam int STAT_FULL_BIT   = 17;
    localparam int STAT_UFLOW_BIT  = 18;
    localparam int STAT_DROP_LSB   = 24;

    // Ceiling log2, used to size pointers from NBUF at elaboration.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/anita_evbuf_ram.sv
// Event store RAM: one write word per cycle, reads an even/odd word pair per cycle.
// Latency: registered read, data valid one clk_i cycle after rd_addr_i.
// Backpressure: none; the caller gates wr_en_i.
// Ports: clk_i; wr_en_i/wr_addr_i/wr_dat_i (word-wide write);
//        rd_addr_i (pair address), rd_dat_o = {odd word, even word}.
module anita_evbuf_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_dat_i,
    input  logic [ADDR_W-2:0]     rd_addr_i,
    output logic [2*DATA_W-1:0]   rd_dat_o
);

    localparam int ROWS = 1 << (ADDR_W - 1);

    // Split into even/odd banks so each bank is a plain 1W/1R array and the
    // double-width read needs no second read port.
    logic [DATA_W-1:0]   bank_even_q [ROWS];
    logic [DATA_W-1:0]   bank_odd_q  [ROWS];
    logic [2*DATA_W-1:0] rd_dat_q;
    logic [2*DATA_W-1:0] rd_dat_d;

    always_comb begin
        rd_dat_d = {bank_odd_q[rd_addr_i], bank_even_q[rd_addr_i]};
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !wr_addr_i[0]) begin
            bank_even_q[wr_addr_i[ADDR_W-1:1]] <= wr_dat_i;
        end
        if (wr_en_i && wr_addr_i[0]) begin
            bank_odd_q[wr_addr_i[ADDR_W-1:1]] <= wr_dat_i;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/anita_event_ring_buffer.sv
// In-order ring of NBUF event buffers between digitizer readout and host readout.
// Latency: read data and read_buffer_o 1 cycle after address; flags update next cycle.
// Backpressure: wr_ready_o low when all buffers are full; writes suppressed, commits dropped and counted.
// Ports: write side event_wr_*/event_done_i/wr_ready_o/write_buffer_o;
//        read side event_rd_*/read_buffer_o/event_valid_o/clear_evt_i;
//        stats stat_clr_i/occupancy_o/status_o.
module anita_event_ring_buffer
    import anita_evbuf_pkg::*;
#(
    parameter int NBUF         = 4,
    parameter int WR_WIDTH     = 16,
    parameter int WR_ADDR_BITS = 6
) (
    input  logic                          clk33_i,
    input  logic                          rst_i,
    input  logic [WR_ADDR_BITS-1:0]       event_wr_addr_i,
    input  logic [WR_WIDTH-1:0]           event_wr_dat_i,
    input  logic                          event_wr_i,
    input  logic                          event_done_i,
    output logic                          wr_ready_o,
    output logic [log2_ceil(NBUF)-1:0]    write_buffer_o,
    input  logic [WR_ADDR_BITS-2:0]       event_rd_addr_i,
    output logic [2*WR_WIDTH-1:0]         event_rd_dat_o,
    output logic [log2_ceil(NBUF)-1:0]    read_buffer_o,
    output logic                          event_valid_o,
    input  logic                          clear_evt_i,
    input  logic                          stat_clr_i,
    output logic [log2_ceil(NBUF):0]      occupancy_o,
    output logic [31:0]                   status_o
);

    localparam int PTR_W = log2_ceil(NBUF);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      COUNT_MAX = CNT_W'(NBUF);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [NBUF-1:0]       full_mask_q, full_mask_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  underflow_q, underflow_d;

    logic ring_full, ring_empty;
    logic do_clear, do_commit, do_drop, uflow_evt, ram_wr_en;

    always_comb begin
        ring_full  = (count_q == COUNT_MAX);
        ring_empty = (count_q == '0);

        // A clear on a full ring frees a slot before the same-cycle commit
        // needs it, so that commit is never dropped.
        do_clear  = clear_evt_i && !ring_empty;
        uflow_evt = clear_evt_i && ring_empty;
        do_commit = event_done_i && (!ring_full || do_clear);
        do_drop   = event_done_i && !do_commit;
        ram_wr_en = event_wr_i && !ring_full;

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        full_mask_d = full_mask_q;
        rd_buf_d    = rd_ptr_q;

        // Clear before set: on a full ring both pointers name the same slot
        // and it must stay marked full.
        if (do_clear) begin
            full_mask_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = rd_ptr_q + PTR_W'(1);
        end
        if (do_commit) begin
            full_mask_d[wr_ptr_q] = 1'b1;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        case ({do_commit, do_clear})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the clearing cycle is kept rather than lost.
        drop_cnt_d = drop_cnt_q;
        if (stat_clr_i) begin
            drop_cnt_d = DROP_CNT_W'(do_drop);
        end else if (do_drop && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
        underflow_d = stat_clr_i ? uflow_evt : (underflow_q | uflow_evt);
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_buf_q    <= '0;
            count_q     <= '0;
            full_mask_q <= '0;
            drop_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_buf_q    <= rd_buf_d;
            count_q     <= count_d;
            full_mask_q <= full_mask_d;
            drop_cnt_q  <= drop_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    anita_evbuf_ram #(
        .ADDR_W (PTR_W + WR_ADDR_BITS),
        .DATA_W (WR_WIDTH)
    ) u_ram (
        .clk_i     (clk33_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i ({wr_ptr_q, event_wr_addr_i}),
        .wr_dat_i  (event_wr_dat_i),
        .rd_addr_i ({rd_ptr_q, event_rd_addr_i}),
        .rd_dat_o  (event_rd_dat_o)
    );

    assign wr_ready_o     = !ring_full;
    assign event_valid_o  = !ring_empty;
    assign occupancy_o    = count_q;
    assign write_buffer_o = wr_ptr_q;
    assign read_buffer_o  = rd_buf_q;

    always_comb begin
        status_o = '0;
        status_o[STAT_RD_PTR_LSB +: STAT_PTR_W]  = STAT_PTR_W'(rd_ptr_q);
        status_o[STAT_WR_PTR_LSB +: STAT_PTR_W]  = STAT_PTR_W'(wr_ptr_q);
        status_o[STAT_MASK_LSB +: STAT_MASK_W]   = STAT_MASK_W'(full_mask_q);
        status_o[STAT_VALID_BIT]                 = !ring_empty;
        status_o[STAT_FULL_BIT]                  = ring_full;
        status_o[STAT_UFLOW_BIT]                 = underflow_q;
        status_o[STAT_DROP_LSB +: DROP_CNT_W]    = drop_cnt_q;
    end

endmodule

// File: tb/tb_anita_event_ring_buffer.sv
module tb_anita_event_ring_buffer;

    localparam int NBUF = 4;
    localparam int W    = 16;
    localparam int AB   = 6;
    localparam int WPB  = 1 << AB;   // words per buffer

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [AB-1:0] event_wr_addr_i = '0;
    logic [W-1:0]  event_wr_dat_i = '0;
    logic          event_wr_i = 1'b0;
    logic          event_done_i = 1'b0;
    logic          wr_ready_o;
    logic [1:0]    write_buffer_o;
    logic [AB-2:0] event_rd_addr_i = '0;
    logic [2*W-1:0] event_rd_dat_o;
    logic [1:0]    read_buffer_o;
    logic          event_valid_o;
    logic          clear_evt_i = 1'b0;
    logic          stat_clr_i = 1'b0;
    logic [2:0]    occupancy_o;
    logic [31:0]   status_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    anita_event_ring_buffer #(.NBUF(NBUF), .WR_WIDTH(W), .WR_ADDR_BITS(AB)) dut (
        .clk33_i         (clk),
        .rst_i           (rst_i),
        .event_wr_addr_i (event_wr_addr_i),
        .event_wr_dat_i  (event_wr_dat_i),
        .event_wr_i      (event_wr_i),
        .event_done_i    (event_done_i),
        .wr_ready_o      (wr_ready_o),
        .write_buffer_o  (write_buffer_o),
        .event_rd_addr_i (event_rd_addr_i),
        .event_rd_dat_o  (event_rd_dat_o),
        .read_buffer_o   (read_buffer_o),
        .event_valid_o   (event_valid_o),
        .clear_evt_i     (clear_evt_i),
        .stat_clr_i      (stat_clr_i),
        .occupancy_o     (occupancy_o),
        .status_o        (status_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_cnt = 0, m_wp = 0, m_rp = 0, m_drops = 0;
    bit        m_uflow = 0;
    logic [15:0] m_mem [NBUF*WPB];
    bit        m_ok [NBUF*WPB];
    logic [31:0] m_rd = '0;
    bit        m_rd_vld = 0;
    int        m_rb = 0;
    bit        live = 0;

    function automatic logic [31:0] exp_status();
        logic [7:0] mask;
        mask = '0;
        for (int i = 0; i < m_cnt; i++) mask[(m_rp + i) % NBUF] = 1'b1;
        return {8'(m_drops), 5'b0, m_uflow, (m_cnt == NBUF), (m_cnt != 0), mask, 4'(m_wp), 4'(m_rp)};
    endfunction

    always @(posedge clk) begin
        int rw;
        bit can_clr, uf, com, drp;
        rw = m_rp * WPB + 2 * int'(event_rd_addr_i);
        m_rd_vld = m_ok[rw] && m_ok[rw + 1];
        if (m_rd_vld) m_rd = {m_mem[rw + 1], m_mem[rw]};
        m_rb = m_rp;
        if (event_wr_i && m_cnt < NBUF) begin
            m_mem[m_wp * WPB + int'(event_wr_addr_i)] = event_wr_dat_i;
            m_ok[m_wp * WPB + int'(event_wr_addr_i)]  = 1;
        end
        if (rst_i) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_drops = 0; m_uflow = 0;
            m_rb = 0; m_rd_vld = 0; live = 1;
        end else begin
            can_clr = clear_evt_i && m_cnt > 0;
            uf      = clear_evt_i && m_cnt == 0;
            com     = event_done_i && (m_cnt < NBUF || can_clr);
            drp     = event_done_i && !com;
            if (can_clr) m_rp = (m_rp + 1) % NBUF;
            if (com)     m_wp = (m_wp + 1) % NBUF;
            m_cnt = m_cnt + int'(com) - int'(can_clr);
            if (stat_clr_i) begin
                m_drops = int'(drp);
                m_uflow = uf;
            end else begin
                if (drp && m_drops < 255) m_drops++;
                m_uflow = m_uflow | uf;
            end
        end
    end

    // Single per-cycle compare against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("occupancy", 32'(occupancy_o), 32'(m_cnt));
            chk("wr_ready", 32'(wr_ready_o), 32'(m_cnt != NBUF));
            chk("event_valid", 32'(event_valid_o), 32'(m_cnt != 0));
            chk("write_buffer", 32'(write_buffer_o), 32'(m_wp));
            chk("read_buffer", 32'(read_buffer_o), 32'(m_rb));
            chk("status", status_o, exp_status());
            if (m_rd_vld) chk("rd_dat", event_rd_dat_o, m_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit();
        event_done_i = 1'b1; tick(); event_done_i = 1'b0;
    endtask

    task automatic clear();
        clear_evt_i = 1'b1; tick(); clear_evt_i = 1'b0;
    endtask

    task automatic fill(input int b);
        for (int a = 0; a < WPB; a++) begin
            event_wr_i = 1'b1;
            event_wr_addr_i = AB'(a);
            event_wr_dat_i = (b == 0) ? 16'(16'hA000 + a) : 16'(b * 16'h1000 + a);
            tick();
        end
        event_wr_i = 1'b0;
    endtask

    initial begin
        int exp_rp_tbl[4];
        exp_rp_tbl = '{1, 2, 3, 0};

        tick(); tick();
        rst_i = 1'b0;
        chk("lit_reset_status", status_o, 32'h0);
        chk("lit_reset_ready", 32'(wr_ready_o), 32'd1);
        chk("lit_reset_valid", 32'(event_valid_o), 32'd0);

        // First event into buffer 0
        fill(0);
        commit();
        chk("lit_occ1", 32'(occupancy_o), 32'd1);
        chk("lit_valid1", 32'(event_valid_o), 32'd1);
        chk("lit_mask1", 32'(status_o[15:8]), 32'h01);
        event_rd_addr_i = 5'd5;
        tick();
        chk("lit_rd_addr5", event_rd_dat_o, 32'hA00BA00A);
        chk("lit_rd_buf0", 32'(read_buffer_o), 32'd0);

        // Fill ring
        for (int b = 1; b < NBUF; b++) begin
            fill(b);
            commit();
        end
        chk("lit_full_ready", 32'(wr_ready_o), 32'd0);
        chk("lit_full_bit", 32'(status_o[17]), 32'd1);
        chk("lit_full_wbuf", 32'(write_buffer_o), 32'd0);

        // Writes while full must not touch buffer 0
        event_wr_i = 1'b1;
        event_wr_addr_i = 6'd10; event_wr_dat_i = 16'hFFFF; tick();
        event_wr_addr_i = 6'd11; tick();
        event_wr_i = 1'b0;
        commit();
        chk("lit_drop1", 32'(status_o[31:24]), 32'd1);
        chk("lit_drop_wbuf", 32'(write_buffer_o), 32'd0);
        tick();
        chk("lit_rd_intact", event_rd_dat_o, 32'hA00BA00A);

        // Drain with wrap, then underflow
        for (int i = 0; i < 4; i++) begin
            clear();
            chk("lit_rdptr_wrap", 32'(status_o[3:0]), 32'(exp_rp_tbl[i]));
        end
        chk("lit_drained", 32'(occupancy_o), 32'd0);
        clear();
        chk("lit_underflow", 32'(status_o[18]), 32'd1);
        chk("lit_underflow_occ", 32'(occupancy_o), 32'd0);

        // Simultaneous done+clear at occupancy 2
        commit(); commit();
        event_done_i = 1'b1; clear_evt_i = 1'b1; tick();
        event_done_i = 1'b0; clear_evt_i = 1'b0;
        chk("lit_simul_occ", 32'(occupancy_o), 32'd2);
        chk("lit_simul_ptrs", 32'(status_o[7:0]), 32'h31);

        // Simultaneous at full: no drop
        commit(); commit();
        event_done_i = 1'b1; clear_evt_i = 1'b1; tick();
        event_done_i = 1'b0; clear_evt_i = 1'b0;
        chk("lit_full_simul_occ", 32'(occupancy_o), 32'd4);
        chk("lit_full_simul_drop", 32'(status_o[31:24]), 32'd1);
        chk("lit_full_simul_full", 32'(status_o[17]), 32'd1);

        // Saturating drop counter
        event_done_i = 1'b1;
        repeat (300) tick();
        event_done_i = 1'b0;
        chk("lit_drop_sat", 32'(status_o[31:24]), 32'hFF);
        stat_clr_i = 1'b1; tick(); stat_clr_i = 1'b0;
        chk("lit_statclr_drop", 32'(status_o[31:24]), 32'h00);
        chk("lit_statclr_uflow", 32'(status_o[18]), 32'd0);
        event_done_i = 1'b1; stat_clr_i = 1'b1; tick();
        event_done_i = 1'b0; stat_clr_i = 1'b0;
        chk("lit_statclr_with_drop", 32'(status_o[31:24]), 32'd1);

        // Reset mid-write at occupancy 3
        clear();
        chk("lit_occ3", 32'(occupancy_o), 32'd3);
        event_wr_i = 1'b1; event_wr_addr_i = 6'd0; event_wr_dat_i = 16'h1234;
        rst_i = 1'b1; tick();
        rst_i = 1'b0; event_wr_i = 1'b0;
        chk("lit_rst_status", status_o, 32'h0);
        chk("lit_rst_occ", 32'(occupancy_o), 32'd0);
        chk("lit_rst_ready", 32'(wr_ready_o), 32'd1);
        chk("lit_rst_valid", 32'(event_valid_o), 32'd0);
        tick();
        chk("lit_ram_kept", event_rd_dat_o, 32'hA00BA00A);
        chk("lit_rst_rdbuf", 32'(read_buffer_o), 32'd0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/anita_event_ring_buffer.md
Name: anita_event_ring_buffer

Overview:
- Parametrised successor to the two-buffer event store that sits between the digitizer readout engine and the 33 MHz PCI/readout host interface.
- Holds NBUF complete events in an in-order ring and allocates the write buffer internally; the writer no longer chooses it.
- Tracks per-buffer full flags, occupancy, dropped events and clears on an empty ring; exposes a 32-bit status word.
- Single clock domain; any clear-event CDC to 250 MHz logic is done outside this block.

Parameters:
NBUF, 4, number of event buffers; power of two, 2..8
WR_WIDTH, 16, write data width; read width is 2*WR_WIDTH
WR_ADDR_BITS, 6, write-side word address bits per event (2^WR_ADDR_BITS write words per buffer)

Ports:
clk33_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
event_wr_addr_i  in  WR_ADDR_BITS  write word address within current write buffer
event_wr_dat_i  in  WR_WIDTH  write data
event_wr_i  in  1  write strobe
event_done_i  in  1  commit current write buffer as a complete event
wr_ready_o  in/out: out  1  a free write buffer exists (ring not full)
write_buffer_o  out  log2(NBUF)  current write buffer index
event_rd_addr_i  in  WR_ADDR_BITS-1  read word address within current read buffer
event_rd_dat_o  out  2*WR_WIDTH  read data; 1-cycle latency
read_buffer_o  out  log2(NBUF)  read buffer index, delayed 1 cycle to align with event_rd_dat_o
event_valid_o  out  1  read buffer holds a complete event (ring not empty)
clear_evt_i  in  1  release current read buffer, advance to next
stat_clr_i  in  1  clear drop counter and underflow flag
occupancy_o  out  log2(NBUF)+1  number of full buffers
status_o  out  32  status word, layout below

Behaviour:
- State: wr_ptr, rd_ptr (log2(NBUF) bits, wrap modulo NBUF), count (0..NBUF), full_mask[NBUF-1:0], drop_cnt[7:0], underflow sticky.
- Reset values: all of the above 0; wr_ready_o=1, event_valid_o=0, read_buffer_o=0, write_buffer_o=0, occupancy_o=0. event_rd_dat_o is RAM output and undefined until the first read.
- Memory: one inferred dual-port RAM of NBUF*2^WR_ADDR_BITS x WR_WIDTH.
  - Write address: {wr_ptr, event_wr_addr_i}.
  - Read address: {rd_ptr, event_rd_addr_i}, 2*WR_WIDTH wide.
  - event_rd_dat_o[WR_WIDTH-1:0] = even (lower-address) word; the upper half is the odd word.
  - Registered read, one clk33_i latency.
- Write: event_wr_i writes only when count<NBUF. When full, writes are suppressed so no unread event is overwritten.
- event_done_i:
  - If count<NBUF: set full_mask[wr_ptr], wr_ptr+1, count+1.
  - If count==NBUF: event dropped, pointers unchanged, drop_cnt+1 saturating at 255.
- clear_evt_i:
  - If count>0: clear full_mask[rd_ptr], rd_ptr+1, count-1.
  - If count==0: ignored, underflow set.
- Simultaneous event_done_i and clear_evt_i, count>0: both pointers advance, count unchanged, masks updated for both indices.
- Simultaneous event_done_i and clear_evt_i, count==0: done takes effect, clear counts as underflow.
- Simultaneous event_done_i and clear_evt_i, count==NBUF: clear frees first, then done commits; no drop.
- Combinational outputs:
  - wr_ready_o = (count!=NBUF)
  - event_valid_o = (count!=0)
  - occupancy_o = count
  - write_buffer_o = wr_ptr
- read_buffer_o = rd_ptr registered once.
- stat_clr_i clears drop_cnt and underflow next cycle. If a drop coincides with stat_clr_i, drop_cnt=1.
- rst_i mid-event discards all buffers. RAM contents are not cleared.
- status_o layout:
  - [3:0] rd_ptr
  - [7:4] wr_ptr
  - [15:8] full_mask, zero-extended
  - [16] event_valid_o
  - [17] ~wr_ready_o
  - [18] underflow
  - [23:19] 0
  - [31:24] drop_cnt

Decomposition:
- Shared package anita_evbuf_pkg: status bit-position constants, drop counter width (8), LOG2 helper function.
- One natural sub-module: anita_evbuf_ram, the inferred asymmetric 1W/2R-width RAM with registered read.
- Pointer and count logic stays in the top level.

Test Plan:
- Reset, write 64 words into buffer 0, event_done_i -> occupancy_o=1, event_valid_o=1, status_o[15:8]=0x01; reading addr 5 returns {word11, word10} one cycle later with read_buffer_o=0.
- Commit 4 events (NBUF=4) -> wr_ready_o=0, status_o[17]=1; a 5th event_done_i gives drop_cnt=1 and wr_ptr=0; writes during full leave buffer 0 data intact.
- clear_evt_i four times -> rd_ptr wraps 0,1,2,3,0, occupancy_o=0; a 5th clear sets status_o[18]=1 with count remaining 0.
- With occupancy 2, assert event_done_i and clear_evt_i in the same cycle -> occupancy stays 2, both pointers +1. Repeat at full -> no drop, full stays asserted.
- Generate 300 drops -> status_o[31:24]=0xFF; stat_clr_i -> 0x00, underflow 0.
- Assert rst_i mid-write at occupancy 3 -> next cycle all pointers/count 0, wr_ready_o=1, event_valid_o=0.
